ifm_rowbuf_ctrl: RTL and testbench
==================================

IFM_ROWBUF_CTRL -- requirements
Module: ifm_rowbuf_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DW, 32, data word width
- AW, 11, row-buffer RAM address width
- ROW_SLOTS, 3, number of row slots in the ring
- MAX_ROW_WORDS, 512, words per slot; ROW_SLOTS*MAX_ROW_WORDS <= 2^AW
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset
- start, in, 1, frame start pulse
- cfg_row_words, in, 10, words per row (1..MAX_ROW_WORDS)
- cfg_num_rows, in, 16, rows per frame
- busy, out, 1, frame in progress
- done, out, 1, one-cycle pulse after the last word of the frame is read out
- s_valid, in, 1, write-stream valid
- s_data, in, DW, write-stream data
- s_ready, out, 1, write-stream ready
- m_valid, out, 1, read-stream valid
- m_data, out, DW, read-stream data
- m_last, out, 1, last word of a row
- m_ready, in, 1, read-stream ready
- ram_ena, out, 1, RAM write-port enable
- ram_wea, out, 1, RAM write enable
- ram_addra, out, AW, RAM write address
- ram_dia, out, DW, RAM write data
- ram_enb, out, 1, RAM read-port enable
- ram_addrb, out, AW, RAM read address
- ram_dob, in, DW, RAM read data, valid exactly one cycle after ram_enb
REQ-003 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have two states. In IDLE, start SHALL latch cfg_*, clear all counters, and enter RUN. In RUN, start SHALL be ignored.
REQ-005 If start arrives with cfg_row_words==0 or cfg_num_rows==0, the block SHALL stay in IDLE and pulse done on the next cycle.
REQ-006 Slot address SHALL be slot*MAX_ROW_WORDS + col, where slot ranges 0..ROW_SLOTS-1 and col ranges 0..cfg_row_words-1.
REQ-007 Write: s_ready = RUN && occ<ROW_SLOTS && rows_written<cfg_num_rows. On s_valid&&s_ready, ram_ena=ram_wea=1 in the same cycle, with ram_dia=s_data and ram_addra at the write slot/col.
REQ-008 The write col SHALL increment per write. At cfg_row_words-1 it SHALL wrap to 0, the write slot SHALL advance (wrapping ROW_SLOTS-1 -> 0), and rows_written SHALL increment.
REQ-009 occ SHALL count complete, unreleased rows (0..ROW_SLOTS). A row completing and a row releasing in the same cycle SHALL leave occ unchanged.
REQ-010 Read: ram_enb SHALL be issued when RUN && occ>0 && rows_read<cfg_num_rows && (output FIFO count + reads in flight) < 2. The read SHALL use the read slot/col.
REQ-011 Data read SHALL enter a 2-entry output FIFO one cycle after ram_enb; m_last SHALL be tagged when col==cfg_row_words-1.
REQ-012 m_valid SHALL equal FIFO non-empty; m_data/m_last SHALL be the FIFO head. A word SHALL be popped on m_valid&&m_ready, and m_data SHALL hold stable while m_valid&&!m_ready.
REQ-013 A zero-bubble stream SHALL be sustained: with m_ready held at 1, m_valid SHALL stay at 1 every cycle after the first word until the row ends.
REQ-014 The read col SHALL wrap at the row end and the read slot SHALL advance. When the m_last word is accepted, the row SHALL be released (occ decrement) and rows_read SHALL increment.
REQ-015 A row SHALL never be released before its m_last word is accepted, so a slot is never overwritten while it is pending readout.
REQ-016 When rows_read reaches cfg_num_rows, done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE. busy = (state==RUN).
REQ-017 A simultaneous write and read on the same slot is impossible, since reads only target complete rows; no address hazard logic SHALL be added.

Reset
REQ-018 On rst, the FSM SHALL go to IDLE and all counters, occ, and the FIFO SHALL clear. s_ready, m_valid, m_last, done, busy, ram_ena, ram_wea, and ram_enb SHALL be 0; addresses and data SHALL be 0.
REQ-019 rst mid-frame SHALL abort immediately. The in-flight RAM read SHALL be discarded, and no done pulse SHALL occur.

Verification
REQ-020 cfg_row_words=4, cfg_num_rows=2, s_valid held at 1, m_ready held at 1 -> writes go to addresses 0..3 then 512..515; 8 words are read in order, m_last on words 4 and 8, then a single done pulse.
REQ-021 ROW_SLOTS=3, m_ready=0, 5 rows of 8 words offered -> s_ready drops after 24 accepted words with occ=3. Raising m_ready resumes writes only after the first m_last is accepted.
REQ-022 Random m_ready toggling over 6 rows of 16 words -> output matches input order exactly; no word is lost or duplicated, and m_data is stable under a stall.
REQ-023 Slot wrap: 4 rows of 2 words -> the 4th row is written at addresses 0..1 again, only after row 0 has been released.
REQ-024 start with cfg_num_rows=0 -> done pulses 1 cycle later, busy stays 0, and no RAM enables are issued.
REQ-025 rst asserted mid-row 2 -> the next cycle shows all outputs 0; a new start then runs a full frame correctly from slot 0.

Source files
------------

// File: rtl/ifm_rowbuf_ctrl.sv
// Input-feature-map row buffer: streams rows into a RAM ring of slots
// and replays complete rows in order through a 2-entry output FIFO.
module ifm_rowbuf_ctrl #(
  parameter int DW            = 32,
  parameter int AW            = 11,
  parameter int ROW_SLOTS     = 3,
  parameter int MAX_ROW_WORDS = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    cfg_row_words,
  input  logic [15:0]   cfg_num_rows,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dia,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_dob
);

  localparam int SW = (ROW_SLOTS > 1) ? $clog2(ROW_SLOTS) : 1;
  localparam int OW = $clog2(ROW_SLOTS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [9:0]    rw_q;
  logic [15:0]   nr_q;
  logic [9:0]    wcol_q, rcol_q;
  logic [SW-1:0] wslot_q, rslot_q;
  logic [15:0]   rows_wr_q, rows_iss_q, rows_rd_q;
  logic [OW-1:0] occ_q;
  logic [DW:0]   fifo_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    cnt_q;
  logic          infl_q, infl_last_q;
  logic          done_q;

  logic          run, cfg_zero, go;
  logic          wr_fire, wr_end, rd_fire, rd_end;
  logic          pop, rel, frame_end;
  logic [AW-1:0] wr_addr, rd_addr;

  always_comb begin
    run       = (state_q == RUN);
    cfg_zero  = (cfg_row_words == 10'd0) || (cfg_num_rows == 16'd0);
    go        = !run && start && !cfg_zero;
    s_ready   = run && (occ_q < OW'(ROW_SLOTS)) && (rows_wr_q < nr_q);
    wr_fire   = s_valid && s_ready;
    wr_end    = (wcol_q == rw_q - 10'd1);
    m_valid   = (cnt_q != 2'd0);
    {m_last, m_data} = fifo_q[rp_q];
    pop       = m_valid && m_ready;
    rel       = pop && m_last;
    frame_end = rel && (rows_rd_q == nr_q - 16'd1);
    // a word popped this cycle frees its FIFO seat for the read issued now
    rd_fire   = run && (occ_q != '0) && (rows_iss_q < rows_wr_q) &&
                (rows_rd_q < nr_q) &&
                ({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});
    rd_end    = (rcol_q == rw_q - 10'd1);
    wr_addr   = AW'(wslot_q) * AW'(MAX_ROW_WORDS) + AW'(wcol_q);
    rd_addr   = AW'(rslot_q) * AW'(MAX_ROW_WORDS) + AW'(rcol_q);
    ram_ena   = wr_fire;
    ram_wea   = wr_fire;
    ram_addra = wr_fire ? wr_addr : '0;
    ram_dia   = wr_fire ? s_data : '0;
    ram_enb   = rd_fire;
    ram_addrb = rd_fire ? rd_addr : '0;
    busy      = run;
    done      = done_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN:  if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q        <= '0;
      nr_q        <= '0;
      wcol_q      <= '0;
      rcol_q      <= '0;
      wslot_q     <= '0;
      rslot_q     <= '0;
      rows_wr_q   <= '0;
      rows_iss_q  <= '0;
      rows_rd_q   <= '0;
      occ_q       <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (!run && start && cfg_zero) || frame_end;
      if (go) begin
        rw_q        <= cfg_row_words;
        nr_q        <= cfg_num_rows;
        wcol_q      <= '0;
        rcol_q      <= '0;
        wslot_q     <= '0;
        rslot_q     <= '0;
        rows_wr_q   <= '0;
        rows_iss_q  <= '0;
        rows_rd_q   <= '0;
        occ_q       <= '0;
        wp_q        <= 1'b0;
        rp_q        <= 1'b0;
        cnt_q       <= '0;
        infl_q      <= 1'b0;
        infl_last_q <= 1'b0;
      end else begin
        if (wr_fire) begin
          if (wr_end) begin
            wcol_q    <= '0;
            wslot_q   <= (wslot_q == SW'(ROW_SLOTS - 1)) ? '0 : wslot_q + SW'(1);
            rows_wr_q <= rows_wr_q + 16'd1;
          end else begin
            wcol_q <= wcol_q + 10'd1;
          end
        end
        if (rd_fire) begin
          if (rd_end) begin
            rcol_q     <= '0;
            rslot_q    <= (rslot_q == SW'(ROW_SLOTS - 1)) ? '0 : rslot_q + SW'(1);
            rows_iss_q <= rows_iss_q + 16'd1;
          end else begin
            rcol_q <= rcol_q + 10'd1;
          end
        end
        occ_q <= occ_q + OW'(wr_fire && wr_end) - OW'(rel);
        if (rel) rows_rd_q <= rows_rd_q + 16'd1;
        infl_q      <= rd_fire;
        infl_last_q <= rd_end;
        if (infl_q) begin
          fifo_q[wp_q] <= {infl_last_q, ram_dob};
          wp_q         <= ~wp_q;
        end
        if (pop) rp_q <= ~rp_q;
        cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_ifm_rowbuf_ctrl.sv
// Bench for ifm_rowbuf_ctrl: frame-level model of write/read order,
// slot addressing, backpressure and done, checked every cycle.
module tb_ifm_rowbuf_ctrl;
  localparam int DW = 32;
  localparam int AW = 11;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [9:0]    cfg_row_words = 0;
  logic [15:0]   cfg_num_rows = 0;
  logic          busy, done;
  logic          s_valid = 0;
  logic [DW-1:0] s_data = 0;
  logic          s_ready;
  logic          m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 0;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia;
  logic [DW-1:0] ram_dob = 0;

  ifm_rowbuf_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_row_words(cfg_row_words), .cfg_num_rows(cfg_num_rows),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dia(ram_dia), .ram_enb(ram_enb), .ram_addrb(ram_addrb),
    .ram_dob(ram_dob)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // frame model state
  bit            busy_e = 0, done_e = 0;
  int            rw_e = 0, nr_e = 0;
  int            wr_cnt = 0, iss_cnt = 0, out_cnt = 0, rel_cnt = 0;
  int            done_cnt = 0;
  int            wr_at_first_last = -1, rel_at_w6 = -1;
  int            wa_log [0:63];
  logic [63:0]   last_log;
  logic [DW-1:0] wdata [0:255];
  bit            prev_stall = 0, prev_nonlast = 0;
  logic [DW-1:0] prev_md;
  logic          prev_ml;

  // stimulus controls
  int            src_total = 0;
  bit            src_en = 0;
  int            mr_mode = 0;
  logic [15:0]   base = 0;

  always @(posedge clk) begin
    #1;
    s_valid = src_en && (wr_cnt < src_total);
    s_data  = {base, 16'(wr_cnt)};
    case (mr_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    bit busy_pre, done_n, acc, sr_e;
    int r, c;
    if (rst) begin
      busy_e = 0; done_e = 0; wr_cnt = 0; iss_cnt = 0;
      out_cnt = 0; rel_cnt = 0; prev_stall = 0; prev_nonlast = 0;
    end else begin
      busy_pre = busy_e;
      done_n   = 0;
      acc      = m_valid && m_ready;
      sr_e     = 0;
      if (busy_e)
        sr_e = ((wr_cnt / rw_e) - rel_cnt < 3) && (wr_cnt / rw_e < nr_e);
      chk("s_ready", s_ready, sr_e);
      chk("busy", busy, busy_e);
      chk("done", done, done_e);
      if (done) done_cnt++;
      if (!busy_e)
        chk("idle_quiet", {ram_ena, ram_wea, ram_enb, m_valid}, 4'b0);
      if (prev_stall)
        chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_ml, prev_md});
      if (prev_nonlast)
        chk("no_bubble", m_valid, 1'b1);
      if (busy_e && s_valid && s_ready) begin
        r = wr_cnt / rw_e; c = wr_cnt % rw_e;
        chk("wr_en", {ram_ena, ram_wea}, 2'b11);
        chk("wr_addr", ram_addra, (r % 3) * 512 + c);
        chk("wr_data", ram_dia, s_data);
        chk("wr_slot_free", r < rel_cnt + 3, 1'b1);
      end
      if (busy_e && ram_enb) begin
        r = iss_cnt / rw_e; c = iss_cnt % rw_e;
        chk("rd_addr", ram_addrb, (r % 3) * 512 + c);
        chk("rd_row_complete", r < wr_cnt / rw_e, 1'b1);
        iss_cnt++;
      end
      if (busy_e && acc) begin
        chk("out_avail", out_cnt < wr_cnt, 1'b1);
        chk("out_data", m_data, wdata[out_cnt]);
        chk("out_last", m_last, (out_cnt % rw_e) == rw_e - 1);
        if (out_cnt < 64) last_log[out_cnt] = m_last;
        if (m_last) begin
          if (rel_cnt == 0) wr_at_first_last = wr_cnt;
          rel_cnt++;
          if (rel_cnt == nr_e) begin busy_e = 0; done_n = 1; end
        end
        out_cnt++;
      end
      if (busy_pre && s_valid && s_ready) begin
        if (wr_cnt < 64) wa_log[wr_cnt] = int'(ram_addra);
        if (wr_cnt == 6) rel_at_w6 = rel_cnt;
        wdata[wr_cnt] = s_data;
        wr_cnt++;
      end
      if (start && !busy_pre) begin
        if (cfg_row_words == 0 || cfg_num_rows == 0) done_n = 1;
        else begin
          busy_e = 1; rw_e = int'(cfg_row_words); nr_e = int'(cfg_num_rows);
          wr_cnt = 0; iss_cnt = 0; out_cnt = 0; rel_cnt = 0;
          wr_at_first_last = -1; rel_at_w6 = -1; last_log = '0;
        end
      end
      prev_stall   = m_valid && !m_ready;
      prev_md      = m_data;
      prev_ml      = m_last;
      prev_nonlast = acc && !m_last;
      done_e       = done_n;
    end
  end

  task automatic start_frame(input int rw, input int nr, input int mode);
    @(posedge clk); #1;
    cfg_row_words = 10'(rw);
    cfg_num_rows  = 16'(nr);
    src_total     = rw * nr;
    base          = base + 16'd1;
    mr_mode       = mode;
    src_en        = 1;
    start         = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk); n++;
    end
    chk({nm, "_done_seen"}, done_cnt != d0, 1'b1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {s_ready, m_valid, m_last, done, busy, ram_ena, ram_wea, ram_enb,
             ram_addra, ram_addrb, ram_dia, m_data}, '0);
  endtask

  initial begin
    int n, d0;
    int exp_a [8];
    exp_a = '{0, 1, 2, 3, 512, 513, 514, 515};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_all_zero("reset_state");

    // two rows of four, free-flowing
    d0 = done_cnt;
    start_frame(4, 2, 0);
    wait_done("a");
    for (int i = 0; i < 8; i++) chk("a_wr_addr", wa_log[i], exp_a[i]);
    chk("a_last_pos", last_log[7:0], 8'h88);
    chk("a_out_cnt", out_cnt, 8);
    repeat (5) @(negedge clk);
    chk("a_done_once", done_cnt - d0, 1);

    // output held off: ring fills after three rows
    start_frame(8, 5, 2);
    n = 0;
    while (wr_cnt < 24 && n < 1000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("b_fill_cnt", wr_cnt, 24);
    chk("b_full_block", s_ready, 1'b0);
    mr_mode = 0;
    wait_done("b");
    chk("b_resume_after_last", wr_at_first_last, 24);
    chk("b_out_cnt", out_cnt, 40);

    // random consumer
    start_frame(16, 6, 1);
    wait_done("c");
    chk("c_out_cnt", out_cnt, 96);

    // slot wrap with short rows
    start_frame(2, 4, 0);
    wait_done("d");
    chk("d_row2_addr", wa_log[4], 1024);
    chk("d_row3_addr0", wa_log[6], 0);
    chk("d_row3_addr1", wa_log[7], 1);
    chk("d_row0_released", rel_at_w6 >= 1, 1'b1);

    // empty frame
    start_frame(4, 0, 0);
    @(negedge clk);
    chk("e_done_pulse", {done, busy}, 2'b10);
    @(negedge clk);
    chk("e_done_gone", {done, busy}, 2'b00);

    // abort mid row 2, then a clean frame
    start_frame(4, 4, 0);
    n = 0;
    while (wr_cnt < 9 && n < 1000) begin @(negedge clk); n++; end
    chk("f_reached_row2", wr_cnt >= 9, 1'b1);
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1; src_en = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_all_zero("f_abort_zero");
    repeat (10) @(negedge clk);
    chk("f_no_done", done_cnt, d0);
    start_frame(3, 3, 0);
    wait_done("f");
    chk("f_restart_addr0", wa_log[0], 0);
    chk("f_restart_addr3", wa_log[3], 512);
    chk("f_out_cnt", out_cnt, 9);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
